// File: rtl/lpc_uart_pkg.sv
// rtl/lpc_uart_pkg.sv - shared constants, state enum and frame helpers for the LPC-to-UART path
// Contents:
//   SYNC_BYTE, FRAME_BYTES, IDX_W     frame layout constants
//   TYPE_W, ADDR_W, DATA_W            record field widths
//   framer_state_t                    framer sequencer states
//   header_byte(), frame_checksum()   frame byte builders
package lpc_uart_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h5A;
  localparam int         FRAME_BYTES = 8;
  localparam int         IDX_W       = $clog2(FRAME_BYTES);

  localparam int TYPE_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SETUP,
    LATCH,
    WAIT_ACK,
    NEXT
  } framer_state_t;

  // Byte 1: cycle type in the high nibble, direction in bit 0.
  function automatic logic [7:0] header_byte(input logic [TYPE_W-1:0] rtype,
                                             input logic              rdir);
    return {rtype, 3'b000, rdir};
  endfunction

  // XOR of frame bytes 1..6; the sync byte is deliberately excluded.
  function automatic logic [7:0] frame_checksum(input logic [TYPE_W-1:0] rtype,
                                                input logic              rdir,
                                                input logic [ADDR_W-1:0] raddr,
                                                input logic [DATA_W-1:0] rdata);
    return header_byte(rtype, rdir) ^ raddr[31:24] ^ raddr[23:16]
         ^ raddr[15:8] ^ raddr[7:0] ^ rdata;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit two-flop synchronizer
// Ports:
//   clock   in   destination clock
//   reset   in   asynchronous, active-low; both flops clear to 0
//   data    in   signal from a foreign clock domain
//   synced  out  data retimed into the clock domain, two cycles late
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic data,
  output logic synced
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= data;
      synced <= meta;
    end
  end

endmodule

// File: rtl/lpc_uart_framer.sv
// rtl/lpc_uart_framer.sv - serializes LPC cycle records into 8-byte frames for uart_tx
// Ports:
//   clock, reset         system clock, asynchronous active-low reset
//   enable               allow new records to be accepted
//   rec_valid/rec_ready  record handshake; rec_type, rec_dir, rec_addr, rec_data record fields
//   tx_data, tx_latch    byte and load strobe towards uart_tx
//   tx_ready             uart_tx ready, asynchronous to clock
//   busy                 frame in progress
//   timeout_count        aborted frames, saturating at 255
module lpc_uart_framer
  import lpc_uart_pkg::*;
#(
  parameter int LATCH_CYCLES   = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [TYPE_W-1:0] rec_type,
  input  logic              rec_dir,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [DATA_W-1:0] rec_data,
  output logic [7:0]        tx_data,
  output logic              tx_latch,
  input  logic              tx_ready,
  output logic              busy,
  output logic [7:0]        timeout_count
);

  // One down-counter serves both the latch pulse width and the ack timeout.
  localparam int CNT_MAX = (LATCH_CYCLES > TIMEOUT_CYCLES) ? LATCH_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LATCH_LOAD   = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_BYTES - 1);

  framer_state_t    state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       frame_q [FRAME_BYTES];
  logic             rdy_s;

  sync_2ff u_rdy_sync (
    .clock  (clock),
    .reset  (reset),
    .data   (tx_ready),
    .synced (rdy_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      tx_data       <= 8'h00;
      tx_latch      <= 1'b0;
      rec_ready     <= 1'b0;
      busy          <= 1'b0;
      timeout_count <= 8'h00;
      for (int i = 0; i < FRAME_BYTES; i++) frame_q[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          rec_ready <= enable;
          busy      <= 1'b0;
          if (rec_valid && rec_ready) begin
            frame_q[0] <= SYNC_BYTE;
            frame_q[1] <= header_byte(rec_type, rec_dir);
            frame_q[2] <= rec_addr[31:24];
            frame_q[3] <= rec_addr[23:16];
            frame_q[4] <= rec_addr[15:8];
            frame_q[5] <= rec_addr[7:0];
            frame_q[6] <= rec_data;
            frame_q[7] <= frame_checksum(rec_type, rec_dir, rec_addr, rec_data);
            idx       <= '0;
            rec_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (rdy_s) begin
            tx_data <= frame_q[idx];
            state   <= SETUP;
          end
        end
        SETUP: begin
          tx_latch <= 1'b1;
          cnt      <= LATCH_LOAD;
          state    <= LATCH;
        end
        LATCH: begin
          if (cnt == '0) begin
            tx_latch <= 1'b0;
            cnt      <= TIMEOUT_LOAD;
            state    <= WAIT_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          // A falling rdy_s means the transmitter took the byte; it wins over expiry.
          if (!rdy_s) begin
            state <= NEXT;
          end else if (cnt == '0) begin
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            busy      <= 1'b0;
            rec_ready <= enable;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            busy      <= 1'b0;
            rec_ready <= enable;
            state     <= IDLE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_uart_framer.sv
// tb/tb_lpc_uart_framer.sv - directed self-checking bench for lpc_uart_framer
module tb_lpc_uart_framer;

  localparam int LATCH_CYCLES   = 8;
  localparam int TIMEOUT_CYCLES = 40;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        rec_valid;
  logic        rec_ready;
  logic [3:0]  rec_type;
  logic        rec_dir;
  logic [31:0] rec_addr;
  logic [7:0]  rec_data;
  logic [7:0]  tx_data;
  logic        tx_latch;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  timeout_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got [$];
  logic [7:0] exp [$];
  bit         stuck;
  int         m_state;
  int         m_cnt;

  lpc_uart_framer #(
    .LATCH_CYCLES   (LATCH_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_type      (rec_type),
    .rec_dir       (rec_dir),
    .rec_addr      (rec_addr),
    .rec_data      (rec_data),
    .tx_data       (tx_data),
    .tx_latch      (tx_latch),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural uart_tx: records the byte seen while the latch is high, drops
  // ready a few cycles later (unless stuck), raises it again after the latch falls.
  initial begin
    tx_ready = 1'b1;
    m_state  = 0;
    m_cnt    = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        m_state  = 0;
        tx_ready = 1'b1;
      end else begin
        case (m_state)
          0: if (tx_latch) begin
               got.push_back(tx_data);
               m_cnt   = 0;
               m_state = 1;
             end
          1: begin
               m_cnt++;
               if (m_cnt == 3) begin
                 if (!stuck) tx_ready = 1'b0;
                 m_state = 2;
               end
             end
          2: if (!tx_latch) begin
               m_cnt   = 0;
               m_state = 3;
             end
          default: begin
               m_cnt++;
               if (m_cnt == 6) begin
                 tx_ready = 1'b1;
                 m_state  = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic push_frame(input logic [3:0] t, input logic d, input logic [31:0] a,
                            input logic [7:0] dt);
    logic [7:0] b [8];
    b[0] = 8'h5A;
    b[1] = {t, 3'b000, d};
    b[2] = a[31:24];
    b[3] = a[23:16];
    b[4] = a[15:8];
    b[5] = a[7:0];
    b[6] = dt;
    b[7] = 8'h00;
    for (int i = 1; i < 7; i++) b[7] = b[7] ^ b[i];
    for (int i = 0; i < 8; i++) exp.push_back(b[i]);
  endtask

  task automatic check_frames(input string tag);
    check($sformatf("%s_len", tag), 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'h0, got_at(i)}, {24'h0, exp[i]});
  endtask

  // Called at a negedge; returns just after the capturing posedge.
  task automatic present(input logic [3:0] t, input logic d, input logic [31:0] a,
                         input logic [7:0] dt, output bit accepted);
    rec_type  = t;
    rec_dir   = d;
    rec_addr  = a;
    rec_data  = dt;
    rec_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rec_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (accepted) begin
      @(posedge clock);
      #1;
    end
    rec_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles, output bit done);
    done   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      cycles++;
    end
  endtask

  task automatic gap();
    repeat (10) @(negedge clock);
    got.delete();
    exp.delete();
  endtask

  initial begin
    bit acc;
    bit done;
    int cyc;
    bit found;

    reset     = 1'b0;
    enable    = 1'b1;
    rec_valid = 1'b0;
    rec_type  = 4'h0;
    rec_dir   = 1'b0;
    rec_addr  = 32'h0;
    rec_data  = 8'h0;
    stuck     = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_tx_latch", {31'h0, tx_latch}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rec_ready", {31'h0, rec_ready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_timeout_count", {24'h0, timeout_count}, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    check("rec_ready_after_release", {31'h0, rec_ready}, 32'h1);

    // Single record
    present(4'h0, 1'b1, 32'h0000_0080, 8'h3C, acc);
    check("t1_accept", {31'h0, acc}, 32'h1);
    push_frame(4'h0, 1'b1, 32'h0000_0080, 8'h3C);
    wait_idle(2000, cyc, done);
    check("t1_busy_drop", {31'h0, done}, 32'h1);
    check_frames("t1");
    check("t1_checksum", {24'h0, got_at(7)}, 32'hBD);

    // Back-to-back: second record held valid while frame 1 runs
    gap();
    present(4'h3, 1'b0, 32'h1234_5678, 8'hA5, acc);
    check("b2b_accept1", {31'h0, acc}, 32'h1);
    push_frame(4'h3, 1'b0, 32'h1234_5678, 8'hA5);
    rec_type  = 4'h9;
    rec_dir   = 1'b1;
    rec_addr  = 32'hDEAD_BEEF;
    rec_data  = 8'h11;
    rec_valid = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (rec_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b_second_ready", {31'h0, found}, 32'h1);
    check("b2b_frame1_done_at_accept", 32'(got.size()), 32'd8);
    check("b2b_busy_low_at_accept", {31'h0, busy}, 32'h0);
    @(posedge clock);
    #1;
    rec_valid = 1'b0;
    push_frame(4'h9, 1'b1, 32'hDEAD_BEEF, 8'h11);
    wait_idle(2000, cyc, done);
    check("b2b_done", {31'h0, done}, 32'h1);
    check_frames("b2b");

    // Checksum corner
    gap();
    present(4'hF, 1'b0, 32'hFFFF_FFFF, 8'hFF, acc);
    check("cs_accept", {31'h0, acc}, 32'h1);
    push_frame(4'hF, 1'b0, 32'hFFFF_FFFF, 8'hFF);
    wait_idle(2000, cyc, done);
    check("cs_done", {31'h0, done}, 32'h1);
    check("cs_byte1", {24'h0, got_at(1)}, 32'hF0);
    check("cs_checksum", {24'h0, got_at(7)}, 32'h0F);
    check_frames("cs");

    // Enable dropped during byte 3
    gap();
    present(4'h2, 1'b1, 32'h0000_0C00, 8'h77, acc);
    check("en_accept", {31'h0, acc}, 32'h1);
    push_frame(4'h2, 1'b1, 32'h0000_0C00, 8'h77);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (got.size() >= 4) begin
        found = 1'b1;
        break;
      end
    end
    check("en_reached_byte3", {31'h0, found}, 32'h1);
    enable    = 1'b0;
    rec_type  = 4'h5;
    rec_dir   = 1'b0;
    rec_addr  = 32'h00C0_FFEE;
    rec_data  = 8'h42;
    rec_valid = 1'b1;
    wait_idle(2000, cyc, done);
    check("en_frame_done", {31'h0, done}, 32'h1);
    check_frames("en_f1");
    repeat (20) @(negedge clock);
    check("en_held_rec_ready", {31'h0, rec_ready}, 32'h0);
    check("en_held_busy", {31'h0, busy}, 32'h0);
    enable = 1'b1;
    present(4'h5, 1'b0, 32'h00C0_FFEE, 8'h42, acc);
    check("en_accept2", {31'h0, acc}, 32'h1);
    push_frame(4'h5, 1'b0, 32'h00C0_FFEE, 8'h42);
    wait_idle(2000, cyc, done);
    check("en_done2", {31'h0, done}, 32'h1);
    check_frames("en_f2");

    // Reset pulsed while byte 5 is latched
    gap();
    present(4'h1, 1'b1, 32'hA1B2_C3D4, 8'h99, acc);
    check("rs_accept", {31'h0, acc}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (got.size() >= 6) begin
        found = 1'b1;
        break;
      end
    end
    check("rs_reached_byte5", {31'h0, found}, 32'h1);
    check("rs_latch_high", {31'h0, tx_latch}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rs_async_tx_latch", {31'h0, tx_latch}, 32'h0);
    check("rs_async_busy", {31'h0, busy}, 32'h0);
    check("rs_async_tx_data", {24'h0, tx_data}, 32'h0);
    check("rs_async_rec_ready", {31'h0, rec_ready}, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    got.delete();
    exp.delete();
    present(4'h6, 1'b0, 32'h0102_0304, 8'h55, acc);
    check("rs_accept2", {31'h0, acc}, 32'h1);
    push_frame(4'h6, 1'b0, 32'h0102_0304, 8'h55);
    wait_idle(2000, cyc, done);
    check("rs_done2", {31'h0, done}, 32'h1);
    check_frames("rs");

    // Stuck transmitter: timeouts and saturation
    gap();
    stuck = 1'b1;
    present(4'h0, 1'b0, 32'h0, 8'h00, acc);
    check("to_accept", {31'h0, acc}, 32'h1);
    wait_idle(500, cyc, done);
    check("to_abort", {31'h0, done}, 32'h1);
    check("to_abort_cycles", 32'(cyc), 32'(2 + LATCH_CYCLES + TIMEOUT_CYCLES));
    check("to_count1", {24'h0, timeout_count}, 32'h1);
    check("to_tx_latch", {31'h0, tx_latch}, 32'h0);
    check("to_rec_ready", {31'h0, rec_ready}, 32'h1);
    check("to_bytes_sent", 32'(got.size()), 32'd1);
    found = 1'b1;
    for (int n = 0; n < 254; n++) begin
      present(4'h0, 1'b0, 32'h0, 8'h00, acc);
      wait_idle(500, cyc, done);
      if (!acc || !done) found = 1'b0;
    end
    check("to_loop_completed", {31'h0, found}, 32'h1);
    check("to_count255", {24'h0, timeout_count}, 32'hFF);
    present(4'h0, 1'b0, 32'h0, 8'h00, acc);
    wait_idle(500, cyc, done);
    check("to_abort256", {31'h0, done}, 32'h1);
    check("to_count_saturated", {24'h0, timeout_count}, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
